// File: rtl/wb_snoop_responder_pkg.sv
// Shared definitions for the snoop responder: one-hot state encoding,
// response encoding, default watchdog limit and a width helper.
`timescale 1ns/1ps
package wb_snoop_responder_pkg;

  typedef enum logic [5:0] {
    ST_IDLE     = 6'b000001,
    ST_TAG_REQ  = 6'b000010,
    ST_TAG_WAIT = 6'b000100,
    ST_DATA_RD  = 6'b001000,
    ST_INV      = 6'b010000,
    ST_RESPOND  = 6'b100000
  } state_t;

  localparam logic RESP_HIT  = 1'b1;
  localparam logic RESP_MISS = 1'b0;

  localparam int DEFAULT_TIMEOUT = 64;

  // Index width that never collapses to zero bits for a single core.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_snoop_responder_if.sv
// Snoop bus slice from the arbiter plus the borrowed cache tag/data port.
// The responder uses the slave modport; the arbiter/cache side uses master.
`timescale 1ns/1ps
interface wb_snoop_responder_if #(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int sw = 1
);
  logic          snoop_req_i;
  logic          snoop_we_i;
  logic [aw-1:0] snoop_adr_i;
  logic [sw-1:0] snoop_src_i;
  logic          snoop_abort_i;
  logic          snoop_busy_o;
  logic          poll_valid_o;
  logic          poll_response_o;
  logic          poll_err_o;
  logic [dw-1:0] snooped_dat_o;
  logic          tag_req_o;
  logic [aw-1:0] tag_adr_o;
  logic          tag_gnt_i;
  logic          tag_rsp_valid_i;
  logic          tag_hit_i;
  logic          dat_req_o;
  logic [dw-1:0] dat_i;
  logic          dat_valid_i;
  logic          inv_o;

  modport slave (
    input  snoop_req_i, snoop_we_i, snoop_adr_i, snoop_src_i, snoop_abort_i,
    input  tag_gnt_i, tag_rsp_valid_i, tag_hit_i, dat_i, dat_valid_i,
    output snoop_busy_o, poll_valid_o, poll_response_o, poll_err_o, snooped_dat_o,
    output tag_req_o, tag_adr_o, dat_req_o, inv_o
  );

  modport master (
    output snoop_req_i, snoop_we_i, snoop_adr_i, snoop_src_i, snoop_abort_i,
    output tag_gnt_i, tag_rsp_valid_i, tag_hit_i, dat_i, dat_valid_i,
    input  snoop_busy_o, poll_valid_o, poll_response_o, poll_err_o, snooped_dat_o,
    input  tag_req_o, tag_adr_o, dat_req_o, inv_o
  );

endinterface

// File: rtl/wb_snoop_responder.sv
// Per-core snoop agent: looks a snooped address up in the local cache, returns
// the cached word on a read hit and invalidates the line on a write hit.
`timescale 1ns/1ps
module wb_snoop_responder
  import wb_snoop_responder_pkg::*;
#(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int num_cores = 2,
  parameter int core_id   = 0,
  parameter int timeout   = DEFAULT_TIMEOUT
) (
  input logic               wb_clk_i,
  input logic               wb_rst_i,
  wb_snoop_responder_if.slave bus
);

  localparam int sw = clog2_min1(num_cores);
  localparam int ww = $clog2(timeout + 1);
  localparam logic [ww-1:0] wd_last = ww'(timeout - 1);

  state_t        state_reg;
  logic [aw-1:0] adr_reg;
  logic          we_reg;
  logic [dw-1:0] data_reg;
  logic          rsp_hit_reg;
  logic          rsp_err_reg;
  logic [ww-1:0] wd_reg;
  logic          tag_req_reg;
  logic          dat_req_reg;
  logic          inv_reg;
  logic          poll_valid_reg;
  logic          poll_response_reg;
  logic          poll_err_reg;
  logic [dw-1:0] snooped_dat_reg;
  logic          wd_expired;

  assign wd_expired = (wd_reg == wd_last);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_reg         <= ST_IDLE;
      adr_reg           <= '0;
      we_reg            <= 1'b0;
      data_reg          <= '0;
      rsp_hit_reg       <= RESP_MISS;
      rsp_err_reg       <= 1'b0;
      wd_reg            <= '0;
      tag_req_reg       <= 1'b0;
      dat_req_reg       <= 1'b0;
      inv_reg           <= 1'b0;
      poll_valid_reg    <= 1'b0;
      poll_response_reg <= 1'b0;
      poll_err_reg      <= 1'b0;
      snooped_dat_reg   <= '0;
    end else begin
      poll_valid_reg <= 1'b0;
      inv_reg        <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // Abort in the same cycle as the strobe cancels the capture entirely.
          if (bus.snoop_req_i && !bus.snoop_abort_i) begin
            adr_reg     <= bus.snoop_adr_i;
            we_reg      <= bus.snoop_we_i;
            rsp_hit_reg <= RESP_MISS;
            rsp_err_reg <= 1'b0;
            if (bus.snoop_src_i == sw'(core_id)) begin
              state_reg <= ST_RESPOND;
            end else begin
              state_reg   <= ST_TAG_REQ;
              tag_req_reg <= 1'b1;
              wd_reg      <= '0;
            end
          end
        end
        ST_TAG_REQ: begin
          wd_reg <= wd_reg + ww'(1);
          if (bus.snoop_abort_i) begin
            tag_req_reg <= 1'b0;
            state_reg   <= ST_IDLE;
          end else if (wd_expired) begin
            tag_req_reg <= 1'b0;
            rsp_err_reg <= 1'b1;
            state_reg   <= ST_RESPOND;
          end else if (bus.tag_gnt_i) begin
            tag_req_reg <= 1'b0;
            state_reg   <= ST_TAG_WAIT;
          end
        end
        ST_TAG_WAIT: begin
          wd_reg <= wd_reg + ww'(1);
          if (bus.snoop_abort_i) begin
            state_reg <= ST_IDLE;
          end else if (wd_expired) begin
            rsp_err_reg <= 1'b1;
            state_reg   <= ST_RESPOND;
          end else if (bus.tag_rsp_valid_i) begin
            if (!bus.tag_hit_i) begin
              state_reg <= ST_RESPOND;
            end else if (we_reg) begin
              inv_reg   <= 1'b1;
              state_reg <= ST_INV;
            end else begin
              dat_req_reg <= 1'b1;
              state_reg   <= ST_DATA_RD;
            end
          end
        end
        ST_DATA_RD: begin
          wd_reg <= wd_reg + ww'(1);
          if (bus.snoop_abort_i) begin
            dat_req_reg <= 1'b0;
            state_reg   <= ST_IDLE;
          end else if (wd_expired) begin
            dat_req_reg <= 1'b0;
            rsp_err_reg <= 1'b1;
            state_reg   <= ST_RESPOND;
          end else if (bus.dat_valid_i) begin
            dat_req_reg <= 1'b0;
            data_reg    <= bus.dat_i;
            rsp_hit_reg <= RESP_HIT;
            state_reg   <= ST_RESPOND;
          end
        end
        // Write snoops report a miss after the invalidate: they never supply data.
        ST_INV: begin
          state_reg <= ST_RESPOND;
        end
        ST_RESPOND: begin
          poll_valid_reg    <= 1'b1;
          poll_response_reg <= rsp_hit_reg;
          poll_err_reg      <= rsp_err_reg;
          if (rsp_hit_reg == RESP_HIT) begin
            snooped_dat_reg <= data_reg;
          end
          state_reg <= ST_IDLE;
        end
        default: begin
          tag_req_reg <= 1'b0;
          dat_req_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.snoop_busy_o    = (state_reg != ST_IDLE);
  assign bus.poll_valid_o    = poll_valid_reg;
  assign bus.poll_response_o = poll_response_reg;
  assign bus.poll_err_o      = poll_err_reg;
  assign bus.snooped_dat_o   = snooped_dat_reg;
  assign bus.tag_req_o       = tag_req_reg;
  assign bus.tag_adr_o       = adr_reg;
  assign bus.dat_req_o       = dat_req_reg;
  assign bus.inv_o           = inv_reg;

endmodule
